// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle signed A+B / A-B evaluated CHUNK bits per clock with a registered carry.
// Optional: define ADDSUB_SAT_EN to clamp Sum on signed overflow instead of wrapping.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] opa, opb, res, res_nx, fin;
    logic             carry, last, cin_msb, ovf;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_chk, b_chk;
    logic [CHUNK:0]   csum;

`ifdef ADDSUB_SAT_EN
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // A wrapped result carries the opposite sign of the true result.
    function automatic logic [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] raw,
                                                  input logic ov);
        if (!ov)
            return raw;
        return (raw < 0) ? SMAX : SMIN;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_comb begin
        a_chk   = opa[int'(idx)*CHUNK +: CHUNK];
        b_chk   = opb[int'(idx)*CHUNK +: CHUNK];
        csum    = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry};
        // Carry into the chunk MSB recovered from the MSB sum bit.
        cin_msb = a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ csum[CHUNK-1];
        ovf     = cin_msb ^ csum[CHUNK];
        last    = (idx == LAST);
        res_nx  = res;
        res_nx[int'(idx)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
`ifdef ADDSUB_SAT_EN
        fin     = saturate(res_nx, ovf);
`else
        fin     = res_nx;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            Sum   <= '0;
            Ovfl  <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    opa   <= A;
                    opb   <= sub ? ~B : B;
                    carry <= sub;
                    idx   <= '0;
                end
            end else begin
                res   <= res_nx;
                carry <= csum[CHUNK];
                idx   <= idx + IW'(1);
                if (last) begin
                    Sum  <= fin;
                    Ovfl <= ovf;
                    Zero <= (fin == '0);
                    done <= 1'b1;
                end
            end
        end
    end
endmodule
